cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter RST_HOLD, default 4: number of cycles CoreRst stays high after Rst deasserts; legal range 1..255.
REQ-002 Parameter CNT_W, default 32: width of the cycle counter and the limit.
REQ-003 Clk  input  1  single system clock; all logic on posedge Clk.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 Mode  input  2  execution mode: 00 free run, 01 single step, 10 run-to-limit, 11 reserved (treated as 00).
REQ-006 Go  input  1  start request, sampled in IDLE only.
REQ-007 Step  input  1  one-cycle step request, sampled in IDLE with Mode=01 only.
REQ-008 Halt  input  1  stop request, sampled in RUN.
REQ-009 CycleLimit  input  CNT_W  cycle budget for Mode=10; latched on Go.
REQ-010 CoreRst  output  1  reset to the processor core.
REQ-011 CoreEn  output  1  clock enable to the processor core; the core advances one cycle per Clk edge while high.
REQ-012 CycleCnt  output  CNT_W  number of enabled core cycles since the last core reset.
REQ-013 Done  output  1  high while in DONE.
REQ-014 State  output  3  current FSM state encoding.

Function
REQ-015 The FSM has states HOLD, IDLE, RUN, STEP, DONE.
REQ-016 HOLD: CoreRst=1, CoreEn=0; after RST_HOLD cycles counted from the first cycle with Rst low, the FSM goes to IDLE.
REQ-017 IDLE: CoreRst=0, CoreEn=0.
  - Go=1 with Mode in {00,11}: go to RUN.
  - Go=1 with Mode=10: latch CycleLimit, then go to RUN, or to DONE if CycleLimit=0.
  - Step=1 with Mode=01: go to STEP.
  - Go has priority over Step.
REQ-018 RUN: CoreEn=1 every cycle.
  - Halt=1: CoreEn=0 in that same cycle (combinational gate), then go to IDLE.
  - Mode=10: go to DONE in the cycle where the enabled count reaches the latched limit.
  - Halt has priority over limit.
REQ-019 STEP: CoreEn=1 for exactly one cycle, then return to IDLE.
REQ-020 DONE: CoreEn=0; Done=1; stay until Rst. Go is ignored in DONE.
REQ-021 CycleCnt increments by 1 on every Clk edge where CoreEn=1.
  - It wraps modulo 2^CNT_W without flag or saturation.
  - It is cleared while CoreRst=1.
REQ-022 Run-to-limit latency: with limit L, exactly L CoreEn-high cycles occur, and Done rises on the cycle after the last one.
REQ-023 Mode changes while in RUN or STEP have no effect until the next IDLE decision.
REQ-024 Step pulses longer than one cycle produce one step per IDLE visit; a held Step therefore yields one step every 2 cycles.

Reset
REQ-025 Rst=1 at any posedge forces HOLD, whatever the current state, including mid-RUN and mid-STEP.
REQ-026 While Rst=1, outputs are CoreRst=1, CoreEn=0, CycleCnt=0, Done=0, State=HOLD, and the hold counter is reloaded.
REQ-027 No asynchronous reset paths exist.

Structure
REQ-028 A shared package holds:
  - the state encodings (HOLD=0, IDLE=1, RUN=2, STEP=3, DONE=4);
  - the Mode constants (MODE_FREE, MODE_STEP, MODE_LIMIT);
  - the RST_HOLD counter width of 8 bits.
REQ-029 One sub-module, rst_stretch, implements the HOLD counter and drives CoreRst; the FSM and cycle counter stay in cpu_run_ctrl.
REQ-030 CoreEn is a registered FSM decode gated combinationally by Halt only; all other outputs are registered.

Verification
REQ-031 Rst high 3 cycles, then low, RST_HOLD=4 -> CoreRst high through the 4th low cycle, State=IDLE on the 5th, CycleCnt=0.
REQ-032 Mode=00, Go pulse, 10 cycles, then Halt pulse -> CoreEn high exactly 10 cycles, low in the Halt cycle, CycleCnt=10, State=IDLE.
REQ-033 Mode=10, CycleLimit=7, Go -> 7 CoreEn cycles, Done=1 on the next cycle, CycleCnt=7; a subsequent Go is ignored.
REQ-034 Mode=10, CycleLimit=0, Go -> DONE with zero CoreEn cycles, CycleCnt=0.
REQ-035 Mode=01, Step held high 6 cycles -> 3 single-cycle CoreEn pulses, CycleCnt=3.
REQ-036 CNT_W=4, Mode=00, run 17 cycles -> CycleCnt wraps to 1; Rst asserted mid-RUN -> next cycle CoreEn=0, CoreRst=1, CycleCnt=0.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared state encodings, mode constants and hold-counter width
package cpu_run_ctrl_pkg;
  typedef enum logic [2:0] {
    S_HOLD = 3'd0,
    S_IDLE = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_e;
  localparam logic [1:0] MODE_FREE  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_LIMIT = 2'b10;
  localparam int HOLD_W = 8;
endpackage

// File: rtl/cpu_run_ctrl_rst_stretch.sv
// rst_stretch: holds core reset high for RST_HOLD cycles after rst_i deasserts
//   clk_i      system clock
//   rst_i      synchronous active-high reset, reloads the hold counter
//   core_rst_o registered core reset
//   release_o  high in the last held cycle, when core reset drops at the next edge
module rst_stretch
  import cpu_run_ctrl_pkg::*;
#(
  parameter int RST_HOLD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic core_rst_o,
  output logic release_o
);
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              rst_q, rst_d;
  assign cnt_d      = rst_i ? HOLD_W'(RST_HOLD) : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  assign rst_d      = cnt_d != '0;
  assign release_o  = !rst_d;
  assign core_rst_o = rst_q;
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
    rst_q <= rst_d;
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/run-to-limit controller for a processor core
//   Clk, Rst    clock and synchronous active-high reset
//   Mode        00 free run, 01 single step, 10 run-to-limit, 11 as 00
//   Go/Step     start and single-step requests, taken in IDLE
//   Halt        stop request in RUN, gates CoreEn in the same cycle
//   CycleLimit  run-to-limit budget, latched on Go
//   CoreRst     stretched core reset
//   CoreEn      core clock enable
//   CycleCnt    enabled core cycles since last core reset
//   Done, State limit reached flag and FSM state
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int RST_HOLD = 4,
  parameter int CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       Mode,
  input  logic             Go,
  input  logic             Step,
  input  logic             Halt,
  input  logic [CNT_W-1:0] CycleLimit,
  output logic             CoreRst,
  output logic             CoreEn,
  output logic [CNT_W-1:0] CycleCnt,
  output logic             Done,
  output logic [2:0]       State
);
  state_e           state_q, state_d;
  logic             lim_q, lim_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] run_q, run_d, run_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;
  logic             release_w;
  rst_stretch #(.RST_HOLD(RST_HOLD)) u_rst (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .core_rst_o(CoreRst),
    .release_o (release_w)
  );
  // Halt is the only combinational path into CoreEn
  assign CoreEn   = state_q == S_STEP || (state_q == S_RUN && !Halt);
  assign run_inc  = run_q + 1'b1;
  // run_q counts enabled cycles of the current run only; CycleCnt spans runs
  assign run_d    = (Rst || state_q == S_IDLE) ? '0 : run_q + CNT_W'(CoreEn);
  assign cnt_d    = (Rst || CoreRst) ? '0 : cnt_q + CNT_W'(CoreEn);
  assign CycleCnt = cnt_q;
  assign Done     = done_q;
  assign State    = state_q;
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    limit_d = limit_q;
    case (state_q)
      S_HOLD: if (release_w) state_d = S_IDLE;
      S_IDLE:
        if (Go) begin
          lim_d   = Mode == MODE_LIMIT;
          limit_d = CycleLimit;
          state_d = Mode == MODE_STEP ? S_IDLE :
                    (Mode == MODE_LIMIT && CycleLimit == '0) ? S_DONE : S_RUN;
        end else if (Step && Mode == MODE_STEP) state_d = S_STEP;
      // last enabled cycle of a limited run moves straight to DONE
      S_RUN:  state_d = Halt ? S_IDLE : (lim_q && run_inc == limit_q) ? S_DONE : S_RUN;
      S_STEP: state_d = S_IDLE;
      S_DONE: state_d = S_DONE;
      default: state_d = S_HOLD;
    endcase
    if (Rst) state_d = S_HOLD;
  end
  always_ff @(posedge Clk) begin
    state_q <= state_d;
    lim_q   <= Rst ? 1'b0 : lim_d;
    limit_q <= Rst ? '0 : limit_d;
    run_q   <= run_d;
    cnt_q   <= cnt_d;
    done_q  <= state_d == S_DONE;
  end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed checks of reset stretch, free run, step, run-to-limit and wrap
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;
  logic        Clk = 1'b0, Rst = 1'b1, Go = 1'b0, Step = 1'b0, Halt = 1'b0;
  logic [1:0]  Mode = 2'b00;
  logic [31:0] CycleLimit = '0;
  logic        core_rst, core_en, done;
  logic [31:0] cyc;
  logic [2:0]  state;
  logic        core_rst4, core_en4, done4;
  logic [3:0]  cyc4;
  logic [2:0]  state4;
  int          n_chk = 0, n_fail = 0;
  int          en, last, k;
  always #5 Clk = ~Clk;
  cpu_run_ctrl #(.RST_HOLD(4), .CNT_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Mode(Mode), .Go(Go), .Step(Step), .Halt(Halt),
    .CycleLimit(CycleLimit), .CoreRst(core_rst), .CoreEn(core_en),
    .CycleCnt(cyc), .Done(done), .State(state)
  );
  cpu_run_ctrl #(.RST_HOLD(4), .CNT_W(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Mode(Mode), .Go(Go), .Step(Step), .Halt(Halt),
    .CycleLimit(CycleLimit[3:0]), .CoreRst(core_rst4), .CoreEn(core_en4),
    .CycleCnt(cyc4), .Done(done4), .State(state4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic do_reset;
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    repeat (4) tick;
  endtask
  initial begin
    repeat (3) tick;
    chk("rst_corerst", core_rst, 1);
    chk("rst_en", core_en, 0);
    chk("rst_cnt", cyc, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state, S_HOLD);
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold_corerst%0d", i), core_rst, 1);
      chk($sformatf("hold_state%0d", i), state, S_HOLD);
      tick;
    end
    chk("rel_state", state, S_IDLE);
    chk("rel_corerst", core_rst, 0);
    chk("rel_cnt", cyc, 0);
    Go = 1'b1;
    tick;
    Go = 1'b0;
    en = 0;
    repeat (10) begin
      en += int'(core_en);
      tick;
    end
    Halt = 1'b1;
    #1;
    chk("halt_en", core_en, 0);
    chk("halt_state", state, S_RUN);
    tick;
    Halt = 1'b0;
    chk("free_en", en, 10);
    chk("free_cnt", cyc, 10);
    chk("free_state", state, S_IDLE);
    do_reset;
    Mode = MODE_LIMIT;
    CycleLimit = 7;
    Go = 1'b1;
    tick;
    Go = 1'b0;
    CycleLimit = 99;
    Mode = MODE_FREE;
    en = 0;
    last = -1;
    for (k = 0; k < 20; k++) begin
      if (done) break;
      if (core_en) begin
        en++;
        last = k;
      end
      tick;
    end
    chk("lim_en", en, 7);
    chk("lim_done_at", k, 7);
    chk("lim_done_after_last", k, last + 1);
    chk("lim_cnt", cyc, 7);
    Go = 1'b1;
    tick;
    Go = 1'b0;
    tick;
    chk("lim_go_ignored_state", state, S_DONE);
    chk("lim_go_ignored_done", done, 1);
    chk("lim_go_ignored_cnt", cyc, 7);
    do_reset;
    Mode = MODE_LIMIT;
    CycleLimit = 0;
    Go = 1'b1;
    tick;
    Go = 1'b0;
    chk("lim0_state", state, S_DONE);
    chk("lim0_done", done, 1);
    chk("lim0_en", core_en, 0);
    repeat (2) tick;
    chk("lim0_cnt", cyc, 0);
    do_reset;
    Mode = MODE_LIMIT;
    CycleLimit = 3;
    Go = 1'b1;
    tick;
    Go = 1'b0;
    repeat (2) tick;
    Halt = 1'b1;
    #1;
    chk("hp_en", core_en, 0);
    tick;
    Halt = 1'b0;
    chk("hp_state", state, S_IDLE);
    chk("hp_cnt", cyc, 2);
    chk("hp_done", done, 0);
    do_reset;
    Mode = MODE_STEP;
    Step = 1'b1;
    en = 0;
    for (int i = 0; i < 6; i++) begin
      en += int'(core_en);
      tick;
    end
    Step = 1'b0;
    repeat (2) tick;
    chk("step_pulses", en, 3);
    chk("step_cnt", cyc, 3);
    chk("step_state", state, S_IDLE);
    do_reset;
    Mode = MODE_FREE;
    Go = 1'b1;
    tick;
    Go = 1'b0;
    repeat (17) tick;
    chk("wrap_cnt4", cyc4, 1);
    chk("wrap_cnt32", cyc, 17);
    chk("wrap_en4", core_en4, 1);
    Rst = 1'b1;
    tick;
    chk("midrst_en", core_en, 0);
    chk("midrst_en4", core_en4, 0);
    chk("midrst_corerst", core_rst, 1);
    chk("midrst_corerst4", core_rst4, 1);
    chk("midrst_cnt", cyc, 0);
    chk("midrst_cnt4", cyc4, 0);
    chk("midrst_state4", state4, S_HOLD);
    chk("midrst_done4", done4, 0);
    Rst = 1'b0;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
